// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - in-order divide request queue feeding the integer divider
//
// Ports:
//   clk, reset (async, active-low), flush
//   enq_valid/enq_ready, enq_srcA, enq_srcB, enq_rob_ptr, enq_hilo_prf_ptr, enq_is_signed
//   div_ready, div_complete   : divider status
//   start_div                 : one-cycle launch; srcA/srcB/rob_ptr/hilo_prf_ptr/is_signed_div valid with it
//   occupancy, empty, div_busy: queue and divider tracking
module div_issue_queue #(
    parameter int LG_W                = 5,
    parameter int LG_DEPTH            = 2,
    parameter int LG_ROB_ENTRIES      = 6,
    parameter int LG_HILO_PRF_ENTRIES = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [(1<<LG_W)-1:0]           enq_srcA,
    input  logic [(1<<LG_W)-1:0]           enq_srcB,
    input  logic [LG_ROB_ENTRIES-1:0]      enq_rob_ptr,
    input  logic [LG_HILO_PRF_ENTRIES-1:0] enq_hilo_prf_ptr,
    input  logic                           enq_is_signed,
    input  logic                           div_ready,
    input  logic                           div_complete,
    output logic                           start_div,
    output logic [(1<<LG_W)-1:0]           srcA,
    output logic [(1<<LG_W)-1:0]           srcB,
    output logic [LG_ROB_ENTRIES-1:0]      rob_ptr,
    output logic [LG_HILO_PRF_ENTRIES-1:0] hilo_prf_ptr,
    output logic                           is_signed_div,
    output logic [LG_DEPTH:0]              occupancy,
    output logic                           empty,
    output logic                           div_busy
);

    localparam int W     = 1 << LG_W;
    localparam int DEPTH = 1 << LG_DEPTH;

    logic [W-1:0]                   mem_a    [DEPTH];
    logic [W-1:0]                   mem_b    [DEPTH];
    logic [LG_ROB_ENTRIES-1:0]      mem_rob  [DEPTH];
    logic [LG_HILO_PRF_ENTRIES-1:0] mem_hilo [DEPTH];
    logic                           mem_sgn  [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [LG_DEPTH:0] head;
    logic [LG_DEPTH:0] tail;
    logic              full;
    logic              enq_fire;

    assign full      = (head[LG_DEPTH] != tail[LG_DEPTH]) &&
                       (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]);
    assign empty     = (head == tail);
    assign occupancy = tail - head;
    assign enq_ready = !full;

    // A full queue refuses enqueue even if the head leaves this same cycle.
    assign enq_fire  = enq_valid && !full && !flush;
    assign start_div = !empty && div_ready && !flush && !div_busy;

    assign srcA          = mem_a[head[LG_DEPTH-1:0]];
    assign srcB          = mem_b[head[LG_DEPTH-1:0]];
    assign rob_ptr       = mem_rob[head[LG_DEPTH-1:0]];
    assign hilo_prf_ptr  = mem_hilo[head[LG_DEPTH-1:0]];
    assign is_signed_div = mem_sgn[head[LG_DEPTH-1:0]];

    // Payload storage needs no reset: it is only observed behind a valid head.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_a[tail[LG_DEPTH-1:0]]    <= enq_srcA;
            mem_b[tail[LG_DEPTH-1:0]]    <= enq_srcB;
            mem_rob[tail[LG_DEPTH-1:0]]  <= enq_rob_ptr;
            mem_hilo[tail[LG_DEPTH-1:0]] <= enq_hilo_prf_ptr;
            mem_sgn[tail[LG_DEPTH-1:0]]  <= enq_is_signed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            div_busy <= 1'b0;
        end else begin
            // start_div is suppressed during flush, so head is stable and
            // collapsing tail onto it empties the queue.
            if (start_div) begin
                head <= head + 1'b1;
            end
            if (flush) begin
                tail <= head;
            end else if (enq_fire) begin
                tail <= tail + 1'b1;
            end
            // A launch wins over a coincident completion; flush leaves the
            // in-flight divide alone since its writeback still arrives.
            if (start_div) begin
                div_busy <= 1'b1;
            end else if (div_complete) begin
                div_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - directed table-driven bench for div_issue_queue
module tb_div_issue_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_srcA;
    logic [31:0] enq_srcB;
    logic [5:0]  enq_rob_ptr;
    logic [2:0]  enq_hilo_prf_ptr;
    logic        enq_is_signed;
    logic        div_ready;
    logic        div_complete;
    logic        start_div;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [5:0]  rob_ptr;
    logic [2:0]  hilo_prf_ptr;
    logic        is_signed_div;
    logic [2:0]  occupancy;
    logic        empty;
    logic        div_busy;

    div_issue_queue dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .enq_srcA         (enq_srcA),
        .enq_srcB         (enq_srcB),
        .enq_rob_ptr      (enq_rob_ptr),
        .enq_hilo_prf_ptr (enq_hilo_prf_ptr),
        .enq_is_signed    (enq_is_signed),
        .div_ready        (div_ready),
        .div_complete     (div_complete),
        .start_div        (start_div),
        .srcA             (srcA),
        .srcB             (srcB),
        .rob_ptr          (rob_ptr),
        .hilo_prf_ptr     (hilo_prf_ptr),
        .is_signed_div    (is_signed_div),
        .occupancy        (occupancy),
        .empty            (empty),
        .div_busy         (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        ev;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rob;
        logic [2:0]  hilo;
        logic        sg;
        logic        dr;
        logic        dc;
        logic        st;
        int          occ;
        logic        er;
        logic        busy;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [5:0]  erob;
        logic [2:0]  ehilo;
        logic        esg;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] fa(input logic [5:0] r);
        return 32'(r) * 32'd37 + 32'd5;
    endfunction
    function automatic logic [31:0] fb(input logic [5:0] r);
        return 32'(r) + 32'd1;
    endfunction
    function automatic logic [2:0] fh(input logic [5:0] r);
        return r[2:0] ^ 3'd5;
    endfunction

    // One cycle: inputs plus outputs expected before the next rising edge.
    // Payload fields are derived from rob so launches can be checked.
    task automatic add_v(input logic fl, input logic ev, input logic [5:0] rob,
                         input logic dr, input logic dc, input logic st,
                         input int occ, input logic er, input logic busy,
                         input logic [5:0] erob);
        vec_t v;
        v.fl = fl; v.ev = ev; v.rob = rob; v.dr = dr; v.dc = dc;
        v.a = fa(rob); v.b = fb(rob); v.hilo = fh(rob); v.sg = rob[0];
        v.st = st; v.occ = occ; v.er = er; v.busy = busy;
        v.erob = erob; v.ea = fa(erob); v.eb = fb(erob);
        v.ehilo = fh(erob); v.esg = erob[0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        flush = 0; enq_valid = 0; enq_srcA = 0; enq_srcB = 0;
        enq_rob_ptr = 0; enq_hilo_prf_ptr = 0; enq_is_signed = 0;
        div_ready = 0; div_complete = 0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        flush = v.fl; enq_valid = v.ev; enq_srcA = v.a; enq_srcB = v.b;
        enq_rob_ptr = v.rob; enq_hilo_prf_ptr = v.hilo; enq_is_signed = v.sg;
        div_ready = v.dr; div_complete = v.dc;
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, ".start_div"}, 32'(start_div), 32'(v.st));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(v.occ));
        check({tag, ".empty"},     32'(empty),     32'(v.occ == 0));
        check({tag, ".enq_ready"}, 32'(enq_ready), 32'(v.er));
        check({tag, ".div_busy"},  32'(div_busy),  32'(v.busy));
        if (v.st) begin
            check({tag, ".rob_ptr"},       32'(rob_ptr),       32'(v.erob));
            check({tag, ".srcA"},          srcA,               v.ea);
            check({tag, ".srcB"},          srcB,               v.eb);
            check({tag, ".hilo_prf_ptr"},  32'(hilo_prf_ptr),  32'(v.ehilo));
            check({tag, ".is_signed_div"}, 32'(is_signed_div), 32'(v.esg));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".occupancy"}, 32'(occupancy), 32'd0);
        check({tag, ".empty"},     32'(empty),     32'd1);
        check({tag, ".enq_ready"}, 32'(enq_ready), 32'd1);
        check({tag, ".start_div"}, 32'(start_div), 32'd0);
        check({tag, ".div_busy"},  32'(div_busy),  32'd0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_vals("in_reset");
        reset = 1'b1;

        //     fl ev rob dr dc  st occ er busy erob
        add_v(0, 0, 0, 1, 0,   0, 0, 1, 0, 0);   // idle after reset
        add_v(0, 0, 0, 1, 0,   0, 0, 1, 0, 0);
        add_v(0, 1, 3, 1, 0,   0, 0, 1, 0, 0);   // enqueue 100/7
        add_v(0, 0, 0, 1, 0,   1, 1, 1, 0, 3);   // launch next cycle
        add_v(0, 0, 0, 0, 0,   0, 0, 1, 1, 0);
        add_v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);   // completion
        add_v(0, 0, 0, 1, 0,   0, 0, 1, 0, 0);
        add_v(0, 1, 1, 0, 0,   0, 0, 1, 0, 0);   // fill rob 1..4
        add_v(0, 1, 2, 0, 0,   0, 1, 1, 0, 0);
        add_v(0, 1, 3, 0, 0,   0, 2, 1, 0, 0);
        add_v(0, 1, 4, 0, 0,   0, 3, 1, 0, 0);
        add_v(0, 1, 5, 0, 0,   0, 4, 0, 0, 0);   // 5th refused
        add_v(0, 0, 0, 1, 0,   1, 4, 0, 0, 1);
        add_v(0, 0, 0, 1, 1,   0, 3, 1, 1, 0);
        add_v(0, 0, 0, 1, 0,   1, 3, 1, 0, 2);
        add_v(0, 0, 0, 1, 1,   0, 2, 1, 1, 0);
        add_v(0, 0, 0, 1, 0,   1, 2, 1, 0, 3);
        add_v(0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
        add_v(0, 0, 0, 1, 0,   1, 1, 1, 0, 4);
        add_v(0, 0, 0, 0, 0,   0, 0, 1, 1, 0);   // rob 5 never entered
        add_v(0, 1, 5, 0, 0,   0, 0, 1, 1, 0);   // queue rob 5,6
        add_v(0, 1, 6, 0, 0,   0, 1, 1, 1, 0);
        add_v(1, 1, 7, 1, 0,   0, 2, 1, 1, 0);   // flush + enqueue rob 7
        add_v(0, 0, 0, 1, 0,   0, 0, 1, 1, 0);
        add_v(0, 0, 0, 1, 1,   0, 0, 1, 1, 0);
        add_v(0, 0, 0, 1, 0,   0, 0, 1, 0, 0);   // nothing left to launch
        add_v(0, 1, 8, 0, 0,   0, 0, 1, 0, 0);
        add_v(0, 0, 0, 1, 1,   1, 1, 1, 0, 8);   // launch + completion together
        add_v(0, 0, 0, 0, 0,   0, 0, 1, 1, 0);   // launch kept busy set
        add_v(0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
        add_v(0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        add_v(0, 1, 9, 0, 0,   0, 0, 1, 0, 0);
        add_v(0, 1, 10, 0, 0,  0, 1, 1, 0, 0);
        add_v(0, 1, 11, 0, 0,  0, 2, 1, 0, 0);
        add_v(0, 1, 12, 0, 0,  0, 3, 1, 0, 0);
        add_v(0, 1, 13, 1, 0,  1, 4, 0, 0, 9);   // full: enqueue refused despite launch
        add_v(0, 0, 0, 0, 0,   0, 3, 1, 1, 0);

        vecs[2].a  = 32'd100; vecs[2].b  = 32'd7;
        vecs[3].ea = 32'd100; vecs[3].eb = 32'd7;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Async reset with 3 queued and a divide in flight.
        @(negedge clk);
        drive_idle();
        div_ready = 1;
        #2 reset = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        #1 check_reset_vals("reset_held");
        reset = 1'b1;
        @(negedge clk);
        #1 check_reset_vals("reset_released");

        // Pointer wrap: 10 enqueue/launch pairs through 4 slots.
        for (int k = 0; k < 10; k++) begin
            logic [5:0] r;
            string      tag;
            r   = 6'(20 + k);
            tag = $sformatf("wrap%0d", k);
            @(negedge clk);
            drive_idle();
            enq_valid = 1; enq_rob_ptr = r; enq_srcA = fa(r); enq_srcB = fb(r);
            enq_hilo_prf_ptr = fh(r); enq_is_signed = r[0];
            #1 check({tag, ".occ_pre"}, 32'(occupancy), 32'd0);
            @(negedge clk);
            drive_idle();
            div_ready = 1;
            #1;
            check({tag, ".start_div"}, 32'(start_div), 32'd1);
            check({tag, ".rob_ptr"},   32'(rob_ptr),   32'(r));
            check({tag, ".srcA"},      srcA,           fa(r));
            check({tag, ".occ_max"},   32'(occupancy <= 3'd4), 32'd1);
            @(negedge clk);
            drive_idle();
            div_complete = 1;
            #1 check({tag, ".div_busy"}, 32'(div_busy), 32'd1);
        end
        @(negedge clk);
        drive_idle();
        #1 check("wrap_end.div_busy", 32'(div_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
